// File: rtl/trcut_pkg.sv
// Shared constants and helpers for the TRCUT self-test wrapper.
// The optional signature register is enabled with the TRCUT_MISR_EN macro.
package trcut_pkg;

  localparam int unsigned CHAIN_LEN  = 4;
  localparam int unsigned LFSR_WIDTH = 4;
  localparam int unsigned MISR_WIDTH = 4;
  localparam int unsigned TAP_HI     = 3;
  localparam int unsigned TAP_LO     = 2;

  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 4'b0001;

  typedef enum logic {
    ModeCapture = 1'b0,
    ModeShift   = 1'b1
  } scan_mode_e;

  // x^4+x^3+1 shift-left step; din folds a serial input in (0 for a plain LFSR).
  function automatic logic [LFSR_WIDTH-1:0] poly_step(input logic [LFSR_WIDTH-1:0] s,
                                                      input logic din);
    return {s[LFSR_WIDTH-2:0], s[TAP_HI] ^ s[TAP_LO] ^ din};
  endfunction

endpackage

// File: rtl/trcut_lfsr.sv
// 4-bit Fibonacci LFSR pattern source with enable and synchronous active-low reset.
module trcut_lfsr
  import trcut_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic serial_out
);

  logic [LFSR_WIDTH-1:0] state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (en) begin
      state <= poly_step(state, 1'b0);
    end
  end

  assign serial_out = state[LFSR_WIDTH-1];

endmodule

// File: rtl/trcut_with_lfsr.sv
// BIST core: LFSR-fed 4-flop scan chain around a two-rail checker.
// Defining TRCUT_MISR_EN adds a 4-bit MISR signature output SIG.
module trcut_with_lfsr #(
  parameter logic [3:0]  SEED      = trcut_pkg::DEFAULT_SEED,
  parameter int unsigned CHAIN_LEN = trcut_pkg::CHAIN_LEN
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SE,
`ifdef TRCUT_MISR_EN
  output logic [3:0] SIG,
`endif
  output logic       SO
);

  import trcut_pkg::*;

  logic                 si;
  logic [CHAIN_LEN-1:0] chain;
  logic                 x0, y0, x1, y1;
  logic                 z0, z1, nc0, nc1;

  trcut_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk       (CLK),
    .rst_n     (RST),
    .en        (SE == ModeShift),
    .serial_out(si)
  );

  // Two-rail checker: pair0 = (f0,f1), pair1 = (f2,f3).
  always_comb begin
    x0  = chain[0];
    y0  = chain[1];
    x1  = chain[2];
    y1  = chain[3];
    z0  = (x0 & x1) | (y0 & y1);
    z1  = (x0 & y1) | (y0 & x1);
    nc0 = ~(x0 ^ y0);
    nc1 = ~(x1 ^ y1);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      chain <= '0;
    end else if (SE == ModeShift) begin
      chain <= {si, chain[CHAIN_LEN-1:1]};
    end else begin
      chain <= {nc1, nc0, z1, z0};
    end
  end

  assign SO = chain[0];

`ifdef TRCUT_MISR_EN
  logic [MISR_WIDTH-1:0] misr;

  // Compacts the bit leaving the chain on this shift (f0 before the edge).
  always_ff @(posedge CLK) begin
    if (!RST) begin
      misr <= '0;
    end else if (SE == ModeShift) begin
      misr <= poly_step(misr, chain[0]);
    end
  end

  assign SIG = misr;
`endif

endmodule

// File: tb/tb_trcut_with_lfsr.sv
// Self-checking bench for trcut_with_lfsr against a behavioural chain model.
// Covers the TRCUT_MISR_EN signature output when that macro is defined.
module tb_trcut_with_lfsr;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic SE  = 1'b0;
  logic SO;
`ifdef TRCUT_MISR_EN
  logic [3:0] SIG;
`endif

  always #5 CLK = ~CLK;

  trcut_with_lfsr dut (
    .CLK(CLK),
    .RST(RST),
    .SE (SE),
`ifdef TRCUT_MISR_EN
    .SIG(SIG),
`endif
    .SO (SO)
  );

  int total = 0;
  int bad   = 0;

  // Documented pattern-source output sequence from seed 0001, period 15.
  int stream [15] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1};

  int       pos;           // index into the SI stream
  bit       m_f [4];       // model chain, m_f[0] = f0
  bit [3:0] m_sig;         // model signature
  bit [3:0] m_alt;         // same signature with one response bit flipped
  int       shift_cnt;     // shifts since last reset, selects the flipped bit
  int       emit_q [$];    // DUT SO bits leaving on shift edges

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic se);
    bit out, a0, b0, a1, b1;
    if (!rst) begin
      pos = 0;
      shift_cnt = 0;
      m_sig = '0;
      m_alt = '0;
      for (int i = 0; i < 4; i++) m_f[i] = 1'b0;
    end else if (se) begin
      out   = m_f[0];
      m_sig = {m_sig[2:0], m_sig[3] ^ m_sig[2] ^ out};
      m_alt = {m_alt[2:0], m_alt[3] ^ m_alt[2] ^ (shift_cnt == 7 ? ~out : out)};
      for (int i = 0; i < 3; i++) m_f[i] = m_f[i+1];
      m_f[3] = stream[pos] != 0;
      pos = (pos + 1) % 15;
      shift_cnt++;
    end else begin
      a0 = m_f[0]; b0 = m_f[1]; a1 = m_f[2]; b1 = m_f[3];
      // Valid two-rail code words are 01/10; nc flags 00/11 per pair.
      m_f[0] = (a0 && a1) || (b0 && b1);
      m_f[1] = (a0 && b1) || (b0 && a1);
      m_f[2] = (a0 == b0);
      m_f[3] = (a1 == b1);
    end
  endtask

  task automatic step(input logic rst, input logic se);
    if (rst && se) emit_q.push_back(int'(SO));
    RST = rst;
    SE  = se;
    @(posedge CLK);
    #1;
    model_update(rst, se);
    check("so", {3'b000, SO}, {3'b000, m_f[0]});
`ifdef TRCUT_MISR_EN
    check("sig", SIG, m_sig);
`endif
  endtask

  task automatic run_vector();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
  endtask

  function automatic logic [3:0] emitted(input int first);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[3-i] = emit_q[first+i][0];
    return v;
  endfunction

  initial begin
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("reset_so", {3'b000, SO}, 4'b0000);

    // 32 vectors of 4 shifts + 1 capture.
    emit_q.delete();
    for (int v = 0; v < 32; v++) run_vector();
    check("resp_vec1", emitted(4), 4'b0010);
    check("resp_vec2", emitted(8), 4'b0011);
`ifdef TRCUT_MISR_EN
    check("sig_flip_sensitive", {3'b000, SIG != m_alt}, 4'b0001);
`endif

    // Reset after two shifts must restart the LFSR and clear the chain.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("midreset_so", {3'b000, SO}, 4'b0000);
    emit_q.delete();
    run_vector();
    run_vector();
    check("midreset_first_load", emitted(0), 4'b0000);
    check("midreset_resp", emitted(4), 4'b0010);

    // Random mode sequences, back-to-back captures and occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 40) != 0, ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
